// File: rtl/glb_shf_bank.sv
// GLB-side single-port SRAM bank for the SHF client: arbitrates SHF reads against writes and buffers read data.
// Define GLB_SHF_RR_ARB_EN for round-robin arbitration on conflicts; default is fixed write priority.
module glb_shf_bank #(
  parameter int SRAM_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 10,
  parameter int RDBUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CCUGLB_Rst,
  input  logic [ADDR_WIDTH-1:0] SHFGLB_InRdAddr,
  input  logic                  SHFGLB_InRdAddrVld,
  output logic                  GLBSHF_InRdAddrRdy,
  output logic [SRAM_WIDTH-1:0] GLBSHF_InRdDat,
  output logic                  GLBSHF_InRdDatVld,
  input  logic                  SHFGLB_InRdDatRdy,
  input  logic [ADDR_WIDTH-1:0] SHFGLB_OutWrAddr,
  input  logic [SRAM_WIDTH-1:0] SHFGLB_OutWrDat,
  input  logic                  SHFGLB_OutWrDatVld,
  output logic                  GLBSHF_OutWrDatRdy
);
  localparam int PW = $clog2(RDBUF_DEPTH);
  localparam int CW = $clog2(RDBUF_DEPTH + 1);

  logic [SRAM_WIDTH-1:0]  mem_q [2**DEPTH_WIDTH];
  logic [SRAM_WIDTH-1:0]  buf_q [RDBUF_DEPTH];
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DEPTH_WIDTH-1:0] rd_idx, wr_idx;
  logic fifo_full, fifo_empty, rd_req, wr_grant, wr_hs, rd_hs, push, pop;

  // Upper address bits alias onto the bank.
  assign rd_idx = SHFGLB_InRdAddr[DEPTH_WIDTH-1:0];
  assign wr_idx = SHFGLB_OutWrAddr[DEPTH_WIDTH-1:0];

  logic unused_addr_hi;
  assign unused_addr_hi = ^{SHFGLB_InRdAddr[ADDR_WIDTH-1:DEPTH_WIDTH],
                            SHFGLB_OutWrAddr[ADDR_WIDTH-1:DEPTH_WIDTH]};

  assign fifo_full  = (cnt_q == CW'(RDBUF_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // A read only competes for the port when the FIFO can take its data.
  assign rd_req     = SHFGLB_InRdAddrVld & ~fifo_full;

`ifdef GLB_SHF_RR_ARB_EN
  logic rd_pri_q, rd_pri_d;

  always_comb begin
    rd_pri_d = rd_pri_q;
    if (CCUGLB_Rst)                            rd_pri_d = 1'b0;
    else if (rd_req && SHFGLB_OutWrDatVld)     rd_pri_d = ~rd_pri_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pri_q <= 1'b0;
    else        rd_pri_q <= rd_pri_d;
  end

  assign wr_grant = ~(rd_req & rd_pri_q);
`else
  assign wr_grant = 1'b1;
`endif

  assign wr_hs              = SHFGLB_OutWrDatVld & wr_grant;
  assign GLBSHF_OutWrDatRdy = wr_hs;
  assign GLBSHF_InRdAddrRdy = ~fifo_full & ~wr_hs;
  assign rd_hs              = SHFGLB_InRdAddrVld & GLBSHF_InRdAddrRdy;
  assign push               = rd_hs & ~CCUGLB_Rst;
  assign pop                = ~fifo_empty & SHFGLB_InRdDatRdy;

  assign GLBSHF_InRdDatVld  = ~fifo_empty;
  assign GLBSHF_InRdDat     = fifo_empty ? '0 : buf_q[head_q];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (CCUGLB_Rst) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is never reset; FIFO slots are only visible once counted valid.
  always_ff @(posedge clk) begin
    if (wr_hs) mem_q[wr_idx] <= SHFGLB_OutWrDat;
    if (push)  buf_q[tail_q] <= mem_q[rd_idx];
  end
endmodule
